// File: rtl/inst_combine_stage.sv
// -----------------------------------------------------------------------------
// inst_combine_stage
//
// Purpose:
//   Sits between rename allocation and dispatch. Each incoming bundle of LANES
//   decoded instructions is merged with its allocated physical register
//   numbers, packed lane by lane into the dispatch format, and held in a
//   two-entry FIFO. A valid/ready handshake on both sides decouples the two
//   pipeline stages; flush drops everything buffered (mispredict recovery).
//
//   Packed lane format (OUT_W = KEEP_W+1+PR_W bits, MSB first):
//     { inst[INST_W-1 : INST_W-KEEP_W], need, need ? pr_num : 0 }
//
// Optional feature:
//   INST_COMB_STALL_CNT_EN - when defined, stall_cnt counts the edges on which
//   the head bundle is valid but dispatch is not ready, saturating at 16'hFFFF
//   and cleared only by reset. When undefined, no counter is built and
//   stall_cnt reads 16'h0000. The port list is the same in both builds.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   in_valid    in   input bundle valid
//   in_ready    out  a bundle can be accepted this cycle (count != 2)
//   in_inst     in   LANES*INST_W, lane i at [i*INST_W +: INST_W]
//   in_pr_num   in   LANES*PR_W,  lane i at [i*PR_W +: PR_W]
//   in_pr_need  in   LANES, bit i set when lane i writes a destination
//   flush       in   discard all buffered bundles
//   out_valid   out  head bundle valid (count != 0)
//   out_ready   in   dispatch accepts the head bundle
//   out_inst    out  LANES*OUT_W packed head bundle, lane i at [i*OUT_W +: OUT_W]
//   stall_cnt   out  16-bit saturating back-pressure counter
// -----------------------------------------------------------------------------
module inst_combine_stage #(
  parameter int LANES  = 4,
  parameter int INST_W = 66,
  parameter int KEEP_W = 49,
  parameter int PR_W   = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*INST_W-1:0]              in_inst,
  input  logic [LANES*PR_W-1:0]                in_pr_num,
  input  logic [LANES-1:0]                     in_pr_need,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*(KEEP_W+1+PR_W)-1:0]     out_inst,
  output logic [15:0]                          stall_cnt
);

  localparam int OUT_W = KEEP_W + 1 + PR_W;
  localparam int BW    = LANES * OUT_W;
  localparam int DROP_W = INST_W - KEEP_W;

  // ---------------------------------------------------------------------------
  // Lane packing (combinational, ahead of storage)
  // ---------------------------------------------------------------------------
  logic [BW-1:0] packed_bundle;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PR_W-1:0] pr_masked;
    // Low instruction bits are not carried into the dispatch format.
    logic            unused_low_bits;

    // A PR number on a lane that does not write a destination is meaningless
    // upstream garbage; force it to zero so dispatch sees a clean field.
    assign pr_masked = in_pr_need[gi] ? in_pr_num[gi*PR_W +: PR_W] : {PR_W{1'b0}};

    assign packed_bundle[gi*OUT_W +: OUT_W] = {
      in_inst[gi*INST_W + INST_W - 1 -: KEEP_W],
      in_pr_need[gi],
      pr_masked
    };

    assign unused_low_bits = ^in_inst[gi*INST_W +: DROP_W];
  end

  // ---------------------------------------------------------------------------
  // Two-entry circular FIFO
  // ---------------------------------------------------------------------------
  logic [BW-1:0] mem_q [2];
  logic [BW-1:0] mem_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q,  count_d;

  logic push;
  logic pop;

  // in_ready depends on registered state only, so there is no combinational
  // path from out_ready back to the producer.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_inst  = mem_q[rd_ptr_q];

  // Flush suppresses both handshakes: the bundle offered in the flush cycle
  // is dropped and a pop in that cycle is not a transfer.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    mem_d[0] = mem_q[0];
    mem_d[1] = mem_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      // Entry data is left in place; only the bookkeeping is cleared.
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = packed_bundle;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      // Push and pop together leave count unchanged.
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Back-pressure counter
  // ---------------------------------------------------------------------------
`ifdef INST_COMB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts every stalled edge, flush cycles included; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: doc/inst_combine_stage.md
# inst_combine_stage

Registered, parametrised successor to the four-lane instruction/physical-register combiner in the rename path. Merges a bundle of `LANES` decoded instructions with the physical register numbers allocated for them, packs each lane into its dispatch format, and holds the result in a two-entry FIFO. The block sits between rename allocation and dispatch, decoupling the two stages with a valid/ready handshake and a flush port for branch mispredict recovery.

## Interface
- `LANES`, 4, instructions per bundle
- `INST_W`, 66, width of one incoming decoded instruction
- `KEEP_W`, 49, upper instruction bits retained, `inst[INST_W-1 : INST_W-KEEP_W]`
- `PR_W`, 6, physical register number width
- `OUT_W`, `KEEP_W+1+PR_W` (56), packed output lane width (derived; do not override)

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `in_valid` in 1: input bundle valid
- `in_ready` out 1: block can accept a bundle this cycle
- `in_inst` in `LANES*INST_W`: lane i at `[i*INST_W +: INST_W]`
- `in_pr_num` in `LANES*PR_W`: lane i at `[i*PR_W +: PR_W]`
- `in_pr_need` in `LANES`: bit i set means lane i writes a destination register
- `flush` in 1: discard all buffered bundles
- `out_valid` out 1: head bundle valid
- `out_ready` in 1: dispatch accepts head bundle
- `out_inst` out `LANES*OUT_W`: packed head bundle, lane i at `[i*OUT_W +: OUT_W]`
- `stall_cnt` out 16: saturating back-pressure counter (see Configuration)

## Operation
- Lane packing (combinational, before storage): `{inst[INST_W-1:INST_W-KEEP_W], need[i], need[i] ? pr_num[i] : {PR_W{1'b0}}}`. A PR number on a lane without `need` set is forced to zero.
- Storage: 2-entry circular FIFO with a 1-bit write pointer, a 1-bit read pointer, and a 2-bit `count` (0..2).
- Push = `in_valid && in_ready && !flush`. Pop = `out_valid && out_ready && !flush`.
- `in_ready = (count != 2)`. This is a register-derived signal only, with no combinational path from `out_ready`.
- `out_valid = (count != 0)`. `out_inst` is driven from the entry at the read pointer.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full (`count==2`): `in_ready=0`, and the input is ignored regardless of `in_valid`.
- Empty: `out_valid=0`, and `out_inst` shows stale entry contents. Dispatch must ignore them.
- `flush`: at the next edge `count`, both pointers and `out_valid` go to 0. A bundle presented with `flush` is dropped, and a pop in the flush cycle is not counted as a transfer. Entry data is not cleared.
- Lanes are independent: a bundle always moves as a unit, with no partial-lane acceptance.

## Timing
- Reset (`rst_n==0` at an edge): `count=0`, pointers 0, all entry storage 0, `out_valid=0`, `in_ready=1`, `out_inst=0`, `stall_cnt=0`.
- Reset asserted mid-transfer overrides push, pop and flush in that cycle.
- Latency: a bundle accepted at edge N is on `out_inst` with `out_valid=1` after edge N. There is one cycle minimum and no bypass path.
- Throughput: one bundle per cycle when `out_ready` is held high.
- `in_valid`/`in_inst` may change freely while `in_ready=0`. The producer holds the bundle until it is accepted.
- `out_inst` stays stable while `out_valid && !out_ready`.

## Configuration
- `INST_COMB_STALL_CNT_EN` defined: `stall_cnt` increments by 1 on each edge where `out_valid && !out_ready`.
  - It saturates at 16'hFFFF.
  - It is cleared only by reset; `flush` does not clear it.
- Macro undefined: no counter register is built and `stall_cnt` is tied to 16'h0000. The port list is identical in both cases.

## Test plan
- Reset then single bundle: `LANES=4`, `in_inst` lane0 = 66'h3_FFFF_FFFF_FFFF_FFFF, `in_pr_num` lane0 = 6'd37, `in_pr_need`=4'b0101, `out_ready=1`.
  - Next cycle `out_valid=1`.
  - Lane0 = {49'h1_FFFF_FFFF_FFFF, 1'b1, 6'd37}.
  - Lanes 1 and 3 have PR field 0 and need bit 0, even with a nonzero `in_pr_num`.
- Back-pressure fill: `out_ready=0`, push bundles A and B on consecutive cycles.
  - `in_ready` drops to 0 after B.
  - A third bundle C is held off.
  - With `out_ready=1`, A, B, C emerge in order, one per cycle.
- Simultaneous push/pop at `count==1`, sustained for 10 cycles: `count` stays 1, and 10 bundles emerge in order with no bubbles after the first.
- Flush while full, with `in_valid=1` on the same cycle:
  - Next cycle `out_valid=0` and `in_ready=1`.
  - The flushed-cycle bundle never appears.
- Stall counter with macro defined: hold `out_valid=1, out_ready=0` for 70000 cycles and check `stall_cnt=16'hFFFF`. With the macro undefined, check it reads 0 throughout.
- Reset mid-stream: assert `rst_n=0` for one edge with `count==2`. Afterwards `out_valid=0`, `in_ready=1` and `stall_cnt=0`.
